// File: rtl/serial_shift_sequencer_if.sv
// rtl/serial_shift_sequencer_if.sv - upstream/downstream handshake bundle for the serial shifter
interface serial_shift_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic        ctrl_dir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        busy;

    modport master (
        output in_valid, data_operandA, ctrl_shiftamt, ctrl_dir, out_ready,
        input  in_ready, out_valid, data_result, busy
    );

    modport slave (
        input  in_valid, data_operandA, ctrl_shiftamt, ctrl_dir, out_ready,
        output in_ready, out_valid, data_result, busy
    );
endinterface

// File: rtl/serial_shift_sequencer.sv
// rtl/serial_shift_sequencer.sv - multi-cycle shifter stepping one 1-bit shift per clock
module one_bit_shifter (
    input  logic [31:0] din,
    input  logic        dir,
    output logic [31:0] dout
);
    // dir=0: logical left with zero fill; dir=1: arithmetic right with sign fill
    assign dout = dir ? {din[31], din[31:1]} : {din[30:0], 1'b0};
endmodule

module serial_shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    serial_shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   acc_next;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               dir_q, dir_d;
    logic               in_ready_q, out_valid_q, busy_q;

    one_bit_shifter u_step (
        .din  (acc_q),
        .dir  (dir_q),
        .dout (acc_next)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.data_operandA;
                    count_d = bus.ctrl_shiftamt;
                    dir_d   = bus.ctrl_dir;
                    state_d = (bus.ctrl_shiftamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d   = acc_next;
                count_d = count_q - SHAMT_W'(1);
                // the step taken at count==1 is the last, so count never reaches 0 here
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // abort keeps acc and dir so the partial value stays observable
        if (flush) begin
            state_d = ST_IDLE;
            count_d = '0;
            acc_d   = acc_q;
            dir_d   = dir_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_SHIFT) || (state_d == ST_DONE);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.data_result = acc_q;
endmodule
